// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front-end: access sizes, FSM states
// and the default RAM depth.
package mem_pkg;

  localparam int DEPTH_DEFAULT = 400001;

  // Access size encodings carried on req_size; 2'b11 is illegal.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DATA,
    ST_WRITE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane steering: extracts a byte/half/word load value from a
// RAM word and merges right-aligned store data into a RAM word.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign shamt = {offset, 3'b000};

  // Shift the addressed lane down for loads and build the lane mask for stores.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    shifted  = word >> shamt;
    load_val = word;
    mask     = '1;
    case (size)
      SZ_B: begin
        load_val = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        mask     = 32'h0000_00FF << shamt;
      end
      SZ_H: begin
        load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        mask     = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    store_word = (word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for a single-port, word-addressed, read-first RAM.
// Byte/half stores use read-modify-write; misaligned or out-of-range
// requests are answered with an error pulse without touching the RAM.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_di,
  input  logic [31:0]       ram_dout
);

  state_t            state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;

  logic              acc_err;
  logic [ADDR_W-1:0] req_word;
  logic [31:0]       load_val;
  logic [31:0]       store_word;

  assign req_word  = {2'b00, req_addr[ADDR_W-1:2]};
  assign req_ready = (state == ST_IDLE) && !rst;

  mem_lane_unit u_lane (
    .word       (ram_dout),
    .wdata      (wdata_q),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (signed_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // Classify the incoming request as illegal (size, alignment or range).
  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      SZ_B:    acc_err = 1'b0;
      SZ_H:    acc_err = req_addr[0];
      SZ_W:    acc_err = |req_addr[1:0];
      default: acc_err = 1'b1;
    endcase
    if (req_word >= ADDR_W'(DEPTH)) acc_err = 1'b1;
  end

  // Sequencer: accept, issue, capture/merge, write back, respond.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every register
    // sees the pre-edge values of its neighbours.
    if (rst) begin
      state      <= ST_IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (acc_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (we_q && size_q == SZ_W) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (we_q) begin
            merged_q <= store_word;
            state    <= ST_WRITE;
          end else begin
            resp_rdata <= load_val;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM pin drive; everything is held at zero while idle or in reset.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (!rst) begin
      case (state)
        ST_ISSUE: begin
          ram_en   = 1'b1;
          ram_we   = we_q && (size_q == SZ_W);
          ram_addr = {2'b00, addr_q[ADDR_W-1:2]};
          ram_di   = ram_we ? wdata_q : 32'h0;
        end
        ST_WRITE: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = {2'b00, addr_q[ADDR_W-1:2]};
          ram_di   = merged_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural read-first RAM.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DEPTH(400001), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .ram_dout   (ram_dout)
  );

  // Read-first RAM model, unwritten words read as zero.
  logic [31:0] mem [int];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
      if (ram_we) mem[int'(ram_addr)] = ram_di;
    end
  end

  // Cycle counter and per-transaction activity monitor (sampled on negedge).
  int          cyc = 0;
  int          acc_cyc;
  int          en_cnt, we_cnt, resp_cnt;
  int          rd_cyc, we_cyc, resp_cyc;
  logic [31:0] we_di, we_addr, resp_data;
  logic        resp_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_en) en_cnt++;
    if (ram_en && !ram_we) rd_cyc = cyc;
    if (ram_we) begin
      we_cnt++;
      we_cyc  = cyc;
      we_di   = ram_di;
      we_addr = ram_addr;
    end
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc  = cyc;
      resp_data = resp_rdata;
      resp_e    = resp_err;
    end
  end

  // Presents one request for a single cycle; returns in cycle N+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    en_cnt = 0; we_cnt = 0; resp_cnt = 0;
    rd_cyc = -1; we_cyc = -1; resp_cyc = -1;
    we_di = '0; we_addr = '0; resp_data = 'x; resp_e = 1'bx;
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 32'hx;
    req_addr  = 32'hx;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    issue(1'b0, size, sgn, addr, 32'h0);
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: en=%b we=%b ready=%b expected 0/0/0", ram_en, ram_we, req_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h expected 1/0/0/0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
  endtask

  task automatic test_word_load();
    mem[5] = 32'h8899AABB;
    load(2'b10, 1'b0, 32'h14);
    tests_run++;
    if (resp_cnt !== 1 || resp_cyc !== acc_cyc + 3 || resp_data !== 32'h8899AABB || resp_e !== 1'b0) begin
      fails++;
      $display("FAIL lw_0x14: cnt=%0d at=+%0d data=%h err=%b expected 1 +3 8899aabb 0",
               resp_cnt, resp_cyc - acc_cyc, resp_data, resp_e);
    end
    tests_run++;
    if (en_cnt !== 1 || we_cnt !== 0 || rd_cyc !== acc_cyc + 1) begin
      fails++;
      $display("FAIL lw_ram_pins: en=%0d we=%0d rd=+%0d expected 1 0 +1", en_cnt, we_cnt, rd_cyc - acc_cyc);
    end
  endtask

  task automatic test_sub_load();
    load(2'b00, 1'b1, 32'h15);
    tests_run++;
    if (resp_data !== 32'hFFFFFFAA || resp_e !== 1'b0) begin
      fails++;
      $display("FAIL lb_0x15: data=%h err=%b expected ffffffaa 0", resp_data, resp_e);
    end
    load(2'b01, 1'b0, 32'h16);
    tests_run++;
    if (resp_data !== 32'h00008899 || resp_e !== 1'b0) begin
      fails++;
      $display("FAIL lhu_0x16: data=%h err=%b expected 00008899 0", resp_data, resp_e);
    end
    load(2'b01, 1'b1, 32'h16);
    tests_run++;
    if (resp_data !== 32'hFFFF8899) begin
      fails++;
      $display("FAIL lh_0x16: data=%h expected ffff8899", resp_data);
    end
    load(2'b00, 1'b0, 32'h17);
    tests_run++;
    if (resp_data !== 32'h00000088) begin
      fails++;
      $display("FAIL lbu_0x17: data=%h expected 00000088", resp_data);
    end
  endtask

  task automatic test_sub_store();
    issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h11);
    settle();
    tests_run++;
    if (rd_cyc !== acc_cyc + 1 || we_cyc !== acc_cyc + 3 || we_cnt !== 1 || en_cnt !== 2) begin
      fails++;
      $display("FAIL sb_timing: rd=+%0d wr=+%0d we_cnt=%0d en_cnt=%0d expected +1 +3 1 2",
               rd_cyc - acc_cyc, we_cyc - acc_cyc, we_cnt, en_cnt);
    end
    tests_run++;
    if (we_di !== 32'h8899AA11 || we_addr !== 32'd5) begin
      fails++;
      $display("FAIL sb_write: di=%h addr=%0d expected 8899aa11 5", we_di, we_addr);
    end
    tests_run++;
    if (resp_cnt !== 1 || resp_cyc !== acc_cyc + 4 || resp_e !== 1'b0 || resp_data !== 32'h0) begin
      fails++;
      $display("FAIL sb_resp: cnt=%0d at=+%0d err=%b data=%h expected 1 +4 0 0",
               resp_cnt, resp_cyc - acc_cyc, resp_e, resp_data);
    end
    load(2'b10, 1'b0, 32'h14);
    tests_run++;
    if (resp_data !== 32'h8899AA11) begin
      fails++;
      $display("FAIL sb_readback: data=%h expected 8899aa11", resp_data);
    end
  endtask

  task automatic test_word_store();
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
    settle();
    tests_run++;
    if (we_cnt !== 1 || en_cnt !== 1 || we_cyc !== acc_cyc + 1 || we_di !== 32'hDEADBEEF || we_addr !== 32'd8) begin
      fails++;
      $display("FAIL sw_write: we_cnt=%0d en_cnt=%0d at=+%0d di=%h addr=%0d expected 1 1 +1 deadbeef 8",
               we_cnt, en_cnt, we_cyc - acc_cyc, we_di, we_addr);
    end
    tests_run++;
    if (resp_cnt !== 1 || resp_cyc !== acc_cyc + 2 || resp_e !== 1'b0) begin
      fails++;
      $display("FAIL sw_resp: cnt=%0d at=+%0d err=%b expected 1 +2 0", resp_cnt, resp_cyc - acc_cyc, resp_e);
    end
    load(2'b10, 1'b0, 32'h20);
    tests_run++;
    if (resp_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_readback: data=%h expected deadbeef", resp_data);
    end
  endtask

  task automatic test_errors();
    logic        we_v   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  size_v [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] addr_v [4] = '{32'h15, 32'h17, 32'h14, 32'h186A04};
    for (int i = 0; i < 4; i++) begin
      issue(we_v[i], size_v[i], 1'b0, addr_v[i], 32'h5555);
      settle();
      tests_run++;
      if (resp_cnt !== 1 || resp_cyc !== acc_cyc + 1 || resp_e !== 1'b1 ||
          resp_data !== 32'h0 || en_cnt !== 0) begin
        fails++;
        $display("FAIL err_%0d: cnt=%0d at=+%0d err=%b data=%h en_cnt=%0d expected 1 +1 1 0 0",
                 i, resp_cnt, resp_cyc - acc_cyc, resp_e, resp_data, en_cnt);
      end
    end
    // Last legal word must still be accepted.
    load(2'b10, 1'b0, 32'h186A00);
    tests_run++;
    if (resp_cnt !== 1 || resp_e !== 1'b0 || en_cnt !== 1 || resp_data !== 32'h0) begin
      fails++;
      $display("FAIL last_word: cnt=%0d err=%b en_cnt=%0d data=%h expected 1 0 1 0",
               resp_cnt, resp_e, en_cnt, resp_data);
    end
  endtask

  task automatic test_reset_mid_store();
    // Reset lands in DATA of a half store.
    issue(1'b1, 2'b01, 1'b0, 32'h14, 32'h1234);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_data_ready: ready=%b expected 1", req_ready);
    end
    settle();
    tests_run++;
    if (we_cnt !== 0 || resp_cnt !== 0 || mem[5] !== 32'h8899AA11) begin
      fails++;
      $display("FAIL rst_data_drop: we_cnt=%0d resp_cnt=%0d word5=%h expected 0 0 8899aa11",
               we_cnt, resp_cnt, mem[5]);
    end
    // Reset lands in WRITE of a byte store: the write must be suppressed.
    issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_write_ready: ready=%b expected 1", req_ready);
    end
    settle();
    tests_run++;
    if (we_cnt !== 0 || resp_cnt !== 0 || mem[5] !== 32'h8899AA11) begin
      fails++;
      $display("FAIL rst_write_drop: we_cnt=%0d resp_cnt=%0d word5=%h expected 0 0 8899aa11",
               we_cnt, resp_cnt, mem[5]);
    end
  endtask

  task automatic test_lane_store();
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFFCAFE);
    settle();
    tests_run++;
    if (we_di !== 32'hCAFEAA11 || we_cnt !== 1 || resp_e !== 1'b0) begin
      fails++;
      $display("FAIL sh_0x16: di=%h we_cnt=%0d err=%b expected cafeaa11 1 0", we_di, we_cnt, resp_e);
    end
    issue(1'b1, 2'b00, 1'b0, 32'h17, 32'h0000005A);
    settle();
    tests_run++;
    if (we_di !== 32'h5AFEAA11 || we_cnt !== 1) begin
      fails++;
      $display("FAIL sb_0x17: di=%h we_cnt=%0d expected 5afeaa11 1", we_di, we_cnt);
    end
    load(2'b00, 1'b1, 32'h17);
    tests_run++;
    if (resp_data !== 32'h0000005A) begin
      fails++;
      $display("FAIL lb_0x17: data=%h expected 0000005a", resp_data);
    end
    load(2'b10, 1'b0, 32'h14);
    tests_run++;
    if (resp_data !== 32'h5AFEAA11) begin
      fails++;
      $display("FAIL lane_readback: data=%h expected 5afeaa11", resp_data);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_sub_load();
    test_sub_store();
    test_word_store();
    test_errors();
    test_reset_mid_store();
    test_lane_store();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store front-end that sits directly upstream of the core's single-port, word-addressed, read-first data RAM.
- Accepts byte-addressed load/store requests from the core's memory stage over a valid/ready handshake.
- Drives the RAM's en/we/addr/di pins and captures dout after the RAM's 1-cycle read latency.
- Handles byte and halfword access with sign/zero extension; sub-word stores use read-modify-write because the RAM is word-only.
- Returns a one-cycle response pulse, with an error flag for misaligned or out-of-range accesses.

Parameters:
- DEPTH, 400001: RAM size in 32-bit words; legal word addresses are 0..DEPTH-1.
- ADDR_W, 32: width of the byte address and of the RAM word address port.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid only with resp_valid.
- ram_en  out  1  to RAM en.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  word address, req_addr[31:2] zero-extended.
- ram_di  out  32  to RAM di.
- ram_dout  in  32  from RAM dout, valid the cycle after a read issue.

Behaviour:
- States: IDLE, ISSUE, DATA, WRITE, RESP.
- req_ready = 1 only in IDLE with rst=0.
- Accept happens in cycle N when req_valid && req_ready. All request fields are registered at the end of cycle N; the inputs are then don't-care until ready returns.
- Error check at accept. Any of the following is an error:
  - req_size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - req_addr[31:2] ≥ DEPTH.
- Error path: IDLE→RESP; resp_valid=1, resp_err=1, resp_rdata=0 in cycle N+1; the RAM is never enabled.
- Load:
  - N+1 ISSUE: ram_en=1, ram_we=0.
  - N+2 DATA: ram_dout sampled; extracted value registered.
  - N+3 RESP: resp_valid=1.
- Word store:
  - N+1 ISSUE: ram_en=1, ram_we=1, ram_di=wdata.
  - N+2 RESP.
- Byte/half store:
  - N+1 ISSUE: read.
  - N+2 DATA: merge wdata into ram_dout at the addressed lane; merged word registered.
  - N+3 WRITE: ram_en=1, ram_we=1, ram_di=merged.
  - N+4 RESP.
- RESP→IDLE unconditionally. There is no response backpressure; the consumer must take the pulse.
- Lanes are little-endian:
  - Byte k = bits [8k+7:8k], with k = addr[1:0].
  - Half = bits [16·addr[1]+15 : 16·addr[1]].
- ram_en and ram_we are 1 only in the states listed above; ram_addr and ram_di are 0 when ram_en=0.
- ram_en and ram_we are forced to 0 whenever rst=1, so no write commits during a reset cycle.
- Reset:
  - State → IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - An in-flight request is dropped with no response.
  - req_ready=1 in the first cycle after rst deasserts.
- Exactly one RAM write per store; zero RAM writes for loads and errors.

Decomposition:
- Package mem_pkg holds:
  - Size encodings (SZ_B, SZ_H, SZ_W).
  - State enum.
  - DEPTH default.
- One combinational sub-module, mem_lane_unit, provides:
  - extract(word, offset, size, signed) → 32-bit load value.
  - merge(word, wdata, offset, size) → 32-bit store word.
- mem_access_ctrl keeps the FSM, request registers and RAM pin drive.

Test Plan:
- Word-aligned load. Preload word 5 = 0x8899AABB; lw 0x14 → resp_valid at N+3, rdata=0x8899AABB, err=0, exactly one ram_en cycle with we=0.
- Signed byte load. lb signed 0x15 → 0xFFFFFFAA.
- Unsigned half load. lhu 0x16 → 0x00008899.
- Sub-word store. sb 0x14, wdata 0x11 → read at N+1, write at N+3 with ram_di=0x8899AA11, resp at N+4; a following lw 0x14 returns 0x8899AA11.
- Word store. sw 0x20, wdata 0xDEADBEEF → ram_we=1 only at N+1, resp at N+2; lw 0x20 returns 0xDEADBEEF.
- Errors. lw 0x15, sh 0x17, size=11, and lw 0x186A04 (word 400001) → resp_err=1 at N+1, rdata=0, ram_en never asserted.
- Reset mid-store. sh 0x14 wdata 0x1234 with rst asserted during DATA → no ram_we pulse, no resp_valid, word 5 unchanged, req_ready=1 one cycle after rst falls.
